// File: rtl/bp_update_scheduler_if.sv
// Bundle between execute-stage resolution ports, the branch stack and the
// branch predictor's single training/repair update port.
interface bp_update_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8,
  parameter int BS_SZ   = 8,
  parameter int PKT_W   = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][PKT_W-1:0] req_packet;
  logic [NUM_REQ-1:0]            req_taken;
  logic [NUM_REQ-1:0]            req_mispred;
  logic [NUM_REQ-1:0][BS_SZ-1:0] req_bmask;
  logic                          squash_valid;
  logic [BS_SZ-1:0]              squash_bmask;
  logic                          clear_valid;
  logic [BS_SZ-1:0]              clear_bmask;

  logic                          resolving_valid_branch;
  logic [PKT_W-1:0]              bs_bp_packet;
  logic                          taken;
  logic                          mispred;
  logic [CNT_W-1:0]              count;
  logic                          full;
  logic [15:0]                   drop_count;

  modport master (
    output req_valid, req_packet, req_taken, req_mispred, req_bmask,
           squash_valid, squash_bmask, clear_valid, clear_bmask,
    input  resolving_valid_branch, bs_bp_packet, taken, mispred,
           count, full, drop_count
  );

  modport slave (
    input  req_valid, req_packet, req_taken, req_mispred, req_bmask,
           squash_valid, squash_bmask, clear_valid, clear_bmask,
    output resolving_valid_branch, bs_bp_packet, taken, mispred,
           count, full, drop_count
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Serializes branch resolutions into the predictor's one update port:
// mispredicts bypass immediately, correct predictions drain from a compacting queue.
module bp_update_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 8,
  parameter int BS_SZ   = 8,
  parameter int PKT_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  bp_update_scheduler_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PKT_W-1:0] pkt;
    logic             taken;
    logic [BS_SZ-1:0] bmask;
  } entry_t;

  entry_t           q_q [DEPTH];
  entry_t           q_d [DEPTH];
  entry_t           surv [DEPTH+1];
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic [15:0]      drop_q, drop_d;
  logic [16:0]      drop_sum;
  logic [BS_SZ-1:0] keep_mask;
  logic             bypass, deq;
  logic [PKT_W-1:0] byp_pkt;
  logic             byp_taken;
  int               n_surv, n_next, n_drop;

  // NOTE: counters and array writes below rely on blocking '=' so each loop
  // iteration sees the previous one's result; this block is purely combinational.
  always_comb begin
    keep_mask = ~({BS_SZ{bus.clear_valid}} & bus.clear_bmask);

    // Squash stored entries, compact survivors toward slot 0, then apply clear.
    for (int i = 0; i <= DEPTH; i++) surv[i] = '0;
    n_surv = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q) &&
          !(bus.squash_valid && |(q_q[i].bmask & bus.squash_bmask))) begin
        surv[n_surv]       = q_q[i];
        surv[n_surv].bmask = q_q[i].bmask & keep_mask;
        n_surv++;
      end
    end

    bypass    = 1'b0;
    byp_pkt   = '0;
    byp_taken = 1'b0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (bus.req_valid[p] && bus.req_mispred[p]) begin
        bypass    = 1'b1;
        byp_pkt   = bus.req_packet[p];
        byp_taken = bus.req_taken[p];
      end
    end
    deq = !bypass && (n_surv != 0);

    bus.resolving_valid_branch = 1'b0;
    bus.bs_bp_packet           = '0;
    bus.taken                  = 1'b0;
    bus.mispred                = 1'b0;
    if (!reset) begin
      if (bypass) begin
        bus.resolving_valid_branch = 1'b1;
        bus.bs_bp_packet           = byp_pkt;
        bus.taken                  = byp_taken;
        bus.mispred                = 1'b1;
      end else if (deq) begin
        bus.resolving_valid_branch = 1'b1;
        bus.bs_bp_packet           = surv[0].pkt;
        bus.taken                  = surv[0].taken;
      end
    end

    for (int i = 0; i < DEPTH; i++) q_d[i] = surv[deq ? i + 1 : i];
    n_next = deq ? n_surv - 1 : n_surv;

    // Append surviving training requests in port order; overflow drops the highest ports.
    n_drop = 0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (bus.req_valid[p] && !bus.req_mispred[p] &&
          !(bus.squash_valid && |(bus.req_bmask[p] & bus.squash_bmask))) begin
        if (n_next < DEPTH) begin
          q_d[n_next].pkt   = bus.req_packet[p];
          q_d[n_next].taken = bus.req_taken[p];
          q_d[n_next].bmask = bus.req_bmask[p] & keep_mask;
          n_next++;
        end else begin
          n_drop++;
        end
      end
    end

    count_d  = CNT_W'(n_next);
    full_d   = (n_next == DEPTH);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
    end
  end

  // NOTE: the entry array has no reset; count_q alone says which slots hold data.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
  end

  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's update
// port and status; a monitor compares them against the DUT on the falling edge.
module tb_bp_update_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 8;
  localparam int BS_SZ   = 8;
  localparam int PKT_W   = 16;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bp_update_scheduler_if #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .BS_SZ(BS_SZ), .PKT_W(PKT_W)) bus ();

  bp_update_scheduler #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .BS_SZ(BS_SZ), .PKT_W(PKT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [PKT_W-1:0] pkt;
    logic             taken;
    logic [BS_SZ-1:0] bmask;
  } ent_t;

  typedef struct {
    logic             valid;
    logic [PKT_W-1:0] pkt;
    logic             taken;
    logic             mispred;
    int               count;
    logic             full;
    int               drop;
  } exp_t;

  ent_t mq[$];
  int   m_drop = 0;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic bit squashed(input logic [BS_SZ-1:0] bm);
    return bus.squash_valid && ((bm & bus.squash_bmask) != '0);
  endfunction

  // Reference model: applies one cycle of squash, clear, issue, enqueue to mq.
  task automatic model_cycle(output exp_t e);
    ent_t             keep[$];
    ent_t             n;
    int               drops;
    logic [BS_SZ-1:0] keep_mask;
    e.valid   = 1'b0;
    e.pkt     = '0;
    e.taken   = 1'b0;
    e.mispred = 1'b0;
    e.count   = mq.size();
    e.full    = (mq.size() == DEPTH);
    e.drop    = m_drop;
    if (reset) begin
      mq.delete();
      m_drop = 0;
      return;
    end
    keep_mask = bus.clear_valid ? ~bus.clear_bmask : '1;
    foreach (mq[i]) begin
      if (!squashed(mq[i].bmask)) begin
        n = mq[i];
        n.bmask = n.bmask & keep_mask;
        keep.push_back(n);
      end
    end
    mq = keep;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (bus.req_valid[p] && bus.req_mispred[p]) begin
        e.valid   = 1'b1;
        e.pkt     = bus.req_packet[p];
        e.taken   = bus.req_taken[p];
        e.mispred = 1'b1;
      end
    end
    if (!e.valid && mq.size() > 0) begin
      n = mq.pop_front();
      e.valid = 1'b1;
      e.pkt   = n.pkt;
      e.taken = n.taken;
    end
    drops = 0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (bus.req_valid[p] && !bus.req_mispred[p] && !squashed(bus.req_bmask[p])) begin
        if (mq.size() < DEPTH) begin
          n.pkt   = bus.req_packet[p];
          n.taken = bus.req_taken[p];
          n.bmask = bus.req_bmask[p] & keep_mask;
          mq.push_back(n);
        end else begin
          drops++;
        end
      end
    end
    m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
  endtask

  task automatic clear_inputs();
    bus.req_valid    = '0;
    bus.req_packet   = '0;
    bus.req_taken    = '0;
    bus.req_mispred  = '0;
    bus.req_bmask    = '0;
    bus.squash_valid = 1'b0;
    bus.squash_bmask = '0;
    bus.clear_valid  = 1'b0;
    bus.clear_bmask  = '0;
  endtask

  task automatic req(input int p, input logic [PKT_W-1:0] pkt, input logic tk,
                     input logic mp, input logic [BS_SZ-1:0] bm);
    bus.req_valid[p]   = 1'b1;
    bus.req_packet[p]  = pkt;
    bus.req_taken[p]   = tk;
    bus.req_mispred[p] = mp;
    bus.req_bmask[p]   = bm;
  endtask

  task automatic squash(input logic [BS_SZ-1:0] bm);
    bus.squash_valid = 1'b1;
    bus.squash_bmask = bm;
  endtask

  // Inputs are already applied; record the expectation and advance one cycle.
  task automatic step();
    exp_t e;
    model_cycle(e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("update",
              bus.resolving_valid_branch === e.valid && bus.bs_bp_packet === e.pkt &&
              bus.taken === e.taken && bus.mispred === e.mispred,
              $sformatf("got v=%b pkt=%h t=%b m=%b want v=%b pkt=%h t=%b m=%b",
                        bus.resolving_valid_branch, bus.bs_bp_packet, bus.taken, bus.mispred,
                        e.valid, e.pkt, e.taken, e.mispred));
        check("status",
              bus.count === CNT_W'(e.count) && bus.full === e.full &&
              bus.drop_count === 16'(e.drop),
              $sformatf("got count=%0d full=%b drop=%0d want count=%0d full=%b drop=%0d",
                        bus.count, bus.full, bus.drop_count, e.count, e.full, e.drop));
      end
    end
  end

  initial begin
    int mp_port;
    clear_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    step();
    step();
    reset = 1'b0;

    // Single training update into an empty queue.
    clear_inputs();
    req(0, 16'h0011, 1'b1, 1'b0, '0);
    step();
    idle(3);

    // Three queued entries, then a mispredict bypass holding the head.
    clear_inputs();
    req(0, 16'h0101, 1'b0, 1'b0, '0);
    req(1, 16'h0102, 1'b1, 1'b0, '0);
    req(2, 16'h0103, 1'b0, 1'b0, '0);
    step();
    clear_inputs();
    req(1, 16'h0016, 1'b1, 1'b1, '0);
    step();
    idle(4);

    // Fill to seven with bypasses holding the head, then overflow.
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      req(0, 16'h0200 + 16'(k), 1'b1, 1'b1, '0);
      req(1, 16'h0210 + 16'(k), 1'b0, 1'b0, '0);
      req(2, 16'h0220 + 16'(k), 1'b1, 1'b0, '0);
      step();
    end
    clear_inputs();
    req(0, 16'h0230, 1'b0, 1'b1, '0);
    req(1, 16'h0231, 1'b1, 1'b0, '0);
    step();
    clear_inputs();
    req(3, 16'h0300, 1'b1, 1'b1, '0);
    req(0, 16'h0301, 1'b1, 1'b0, '0);
    req(1, 16'h0302, 1'b0, 1'b0, '0);
    req(2, 16'h0303, 1'b1, 1'b0, '0);
    step();
    clear_inputs();
    req(0, 16'h0304, 1'b0, 1'b0, '0);
    step();
    idle(10);

    // Squash removes the 2nd and 4th entries while a bypass holds the head.
    clear_inputs();
    req(0, 16'h0401, 1'b0, 1'b0, 8'h01);
    req(1, 16'h0402, 1'b1, 1'b0, 8'h04);
    req(2, 16'h0403, 1'b0, 1'b0, 8'h00);
    req(3, 16'h0404, 1'b1, 1'b0, 8'h06);
    step();
    clear_inputs();
    req(0, 16'h04FF, 1'b1, 1'b1, '0);
    squash(8'h04);
    step();
    idle(3);

    // Head squashed in the cycle it would issue; the next entry issues instead.
    clear_inputs();
    req(0, 16'h0501, 1'b1, 1'b0, 8'h02);
    req(1, 16'h0502, 1'b0, 1'b0, 8'h00);
    step();
    clear_inputs();
    squash(8'h02);
    step();
    idle(2);

    // Clear a mask bit, then squash on it: nothing is removed.
    clear_inputs();
    req(0, 16'h0601, 1'b1, 1'b0, 8'h01);
    req(1, 16'h0602, 1'b0, 1'b0, 8'h01);
    req(2, 16'h0603, 1'b1, 1'b0, 8'h01);
    step();
    clear_inputs();
    req(3, 16'h06FF, 1'b0, 1'b1, '0);
    bus.clear_valid = 1'b1;
    bus.clear_bmask = 8'h01;
    step();
    clear_inputs();
    squash(8'h01);
    step();
    idle(4);

    // Reset in the middle of a drain discards the queue.
    clear_inputs();
    for (int p = 0; p < NUM_REQ; p++) req(p, 16'h0700 + 16'(p), 1'b1, 1'b0, '0);
    step();
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(3);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      reset   = ($urandom_range(0, 149) == 0);
      mp_port = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_REQ - 1)) : -1;
      for (int p = 0; p < NUM_REQ; p++) begin
        if (p == mp_port || $urandom_range(0, 2) == 0)
          req(p, PKT_W'($urandom), 1'($urandom_range(0, 1)), p == mp_port,
              BS_SZ'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 7) == 0) squash(BS_SZ'($urandom_range(1, 15)));
      if ($urandom_range(0, 5) == 0) begin
        bus.clear_valid = 1'b1;
        bus.clear_bmask = BS_SZ'($urandom_range(1, 15));
      end
      step();
    end
    reset = 1'b0;
    idle(DEPTH + 2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clock);
      #1;
    end
    check("drain", exp_q.size() == 0,
          $sformatf("got %0d pending expectations want 0", exp_q.size()));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bp_update_scheduler.md
# bp_update_scheduler

Serializes branch-resolution training updates from multiple execute-stage resolution ports into the branch predictor's single update port (`resolving_valid_branch`, `bs_bp_packet`, `taken`, `mispred`). Mispredicted resolutions bypass to the predictor in the same cycle so the BHR is repaired immediately. Correctly-predicted resolutions are buffered in a compacting queue and drained one per cycle. Queued entries carry a branch mask, so wrong-path updates are discarded on a squash.

## Interface
- `NUM_REQ`, default `` `N ``: number of resolution request ports.
- `DEPTH`, default 8: queue entries.
- `BS_SZ`, default 8: branch-mask width, one bit per branch-stack slot.
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  [NUM_REQ]  resolution request per port.
- `req_packet`  in  BRANCH_PREDICTOR_PACKET [NUM_REQ]  packet carried by the branch.
- `req_taken`  in  [NUM_REQ]  resolved direction.
- `req_mispred`  in  [NUM_REQ]  resolution disagreed with the prediction.
- `req_bmask`  in  [NUM_REQ][BS_SZ]  older unresolved branches this branch depends on.
- `squash_valid`  in  1  branch-stack squash this cycle.
- `squash_bmask`  in  [BS_SZ]  slots being squashed.
- `clear_valid`  in  1  correct resolution frees branch-stack slots.
- `clear_bmask`  in  [BS_SZ]  slots to clear from all masks.
- `resolving_valid_branch`  out  1  update valid to the predictor.
- `bs_bp_packet`  out  BRANCH_PREDICTOR_PACKET  update packet.
- `taken`  out  1  forwarded `req_taken` of the issued update.
- `mispred`  out  1  forwarded `req_mispred` of the issued update.
- `count`  out  $clog2(DEPTH+1)  valid queue entries (registered).
- `full`  out  1  `count == DEPTH`.
- `drop_count`  out  16  saturating count of updates lost to overflow.

## Operation
- Precondition: at most one `req_mispred` is asserted per cycle. The bench must never drive more than one.
- Mispredict bypass: a request with `req_valid && req_mispred` drives the outputs combinationally in the same cycle, with `mispred=1`. It is never enqueued, and the queue head is held.
- Every other valid request is a training update and is enqueued. It never bypasses.
- Queue layout: entries are contiguous from slot 0, and slot 0 is the head. Each entry stores {packet, taken, bmask}.
- Per-cycle order of effects:
  1. Squash: if `squash_valid`, remove every stored and incoming entry with `(bmask & squash_bmask) != 0`, then compact.
  2. Clear: if `clear_valid`, every stored and incoming bmask becomes `&= ~clear_bmask`.
  3. Issue: with no bypass, the first surviving entry is driven with `mispred=0` and dequeued. A squashed head is never issued.
  4. Enqueue: surviving non-mispred requests are appended in ascending port index.
- Free slots in a cycle = `DEPTH - survivors + (dequeued ? 1 : 0)`.
- Overflow: requests beyond the free slots are dropped, highest port index first. `drop_count` adds the number dropped and saturates at 16'hFFFF. Squashed requests do not count as drops.
- Output idle value: when nothing is issued, `resolving_valid_branch=0` and `bs_bp_packet`, `taken` and `mispred` are all 0.
- The bypassed mispredict is not checked against `squash_bmask`. The branch stack squashes only younger slots.

## Timing
- Reset (`reset` high at a clock edge):
  - `count=0`, `full=0`, `drop_count=0`, and the queue is emptied.
  - While `reset` is high, `resolving_valid_branch` is forced to 0, nothing is enqueued, and `drop_count` does not change.
  - A reset mid-drain discards all entries.
- Latency:
  - Mispredict: 0 cycles.
  - Training update into an empty queue with no competing bypass: issued the cycle after its request.
  - Training updates issue at 1 per cycle, delayed by 1 cycle per intervening bypass.
- Outputs: `count`, `full` and `drop_count` are registered. The update port is combinational from the head registers plus the request inputs.
- Simultaneous events:
  - Squash, clear, bypass and a full queue may all occur in one cycle. Apply them in the stated order.
  - A request at `full` when a dequeue occurs that cycle takes the freed slot.

## Test plan
- Reset, then request on port 0 with taken=1, mispred=0 at cycle 1. Expect the port to idle in cycle 1, then `resolving_valid_branch=1, taken=1, mispred=0` in cycle 2, with `count` going 0→1→0.
- Queue holds 3 entries, and a mispred request arrives on port 1 with BHR_state=5'b10110. Expect same-cycle output of that packet with `mispred=1`, the head held, and `count` staying at 3. The next 3 cycles drain the entries in FIFO order.
- DEPTH=8 with `count=7` and no dequeue (a bypass occurs), plus 3 training requests. Expect port 0 enqueued, ports 1 and 2 dropped, `count=8`, `full=1` and `drop_count=2`.
- Entries with bmasks {0001, 0100, 0000, 0110} and squash_bmask=0100. Expect the 2nd and 4th removed, `count=2`, and the remaining entries issued in order 0001, then 0000.
- Head bmask 0010 is squashed in the same cycle it would issue, with entry 2 bmask 0000. Expect entry 2 issued that cycle and `count` reduced by 2.
- Clear_bmask=0001 in cycle N, then squash_bmask=0001 in cycle N+1. Expect no entries removed, because the mask bit was cleared first.
